// File: rtl/ddrx_pkg.sv
// Shared types and constants for the DDR3 power-up / initialization sequencer.
package ddrx_pkg;

    localparam int CNT_W    = 16;
    localparam int BA_W     = 3;
    localparam int ADDR_W   = 13;
    localparam int TXPR_W   = 5;
    localparam int TMRD_W   = 4;
    localparam int TMOD_W   = 5;
    localparam int TZQ_W    = 5;

    localparam int                NUM_STEPS = 5;
    localparam logic [ADDR_W-1:0] ZQCL_ADDR = 13'h0400;

    typedef enum logic [1:0] {
        NOP  = 2'd0,
        MRS  = 2'd1,
        ZQCL = 2'd2
    } init_cmd_t;

    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        CKE_WAIT = 3'd1,
        XPR_WAIT = 3'd2,
        ISSUE    = 3'd3,
        GAP      = 3'd4,
        DONE     = 3'd5
    } init_state_t;

    typedef struct packed {
        init_cmd_t         op;
        logic [BA_W-1:0]   ba;
        logic [ADDR_W-1:0] addr;
    } init_cmd_s;

    // A configured delay of 0 behaves as a 1-cycle delay.
    function automatic logic [CNT_W-1:0] min_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/config_if.sv
// Controller configuration fields consumed by the init sequencer.
interface config_if;
    import ddrx_pkg::*;

    logic [ADDR_W-1:0] msr0;
    logic [ADDR_W-1:0] msr1;
    logic [ADDR_W-1:0] msr2;
    logic [ADDR_W-1:0] msr3;
    logic [TXPR_W-1:0] tXPR;
    logic [TMRD_W-1:0] tMRD;
    logic [TMOD_W-1:0] tMOD;
    logic [TZQ_W-1:0]  tZQinit;

    modport master (output msr0, msr1, msr2, msr3, tXPR, tMRD, tMOD, tZQinit);
    modport slave  (input  msr0, msr1, msr2, msr3, tXPR, tMRD, tMOD, tZQinit);
endinterface

// File: rtl/ddrx_delay_cnt.sv
// Loadable 16-bit down-counter shared by every wait of the init sequencer.
// Reset preloads RST_VAL so the first wait needs no explicit load.
// expired is high while the count sits at 1; the count parks at 0.
module ddrx_delay_cnt
    import ddrx_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = 16'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, otherwise decrement until zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ddrx_init_seq.sv
// DDR3 power-up sequencer: RESET#/CKE timing, then MR2, MR3, MR1, MR0, ZQCL.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RST_HOLD | RESET# low, counting T_RESET_CYC
// CKE_WAIT | RESET# high, CKE low, counting T_CKE_CYC
// XPR_WAIT | CKE high, counting tXPR before the first command
// ISSUE    | command of step_q offered, waiting for cmd_ready
// GAP      | post-command delay (tMRD / tMOD / tZQinit)
// DONE     | initialization complete, held until rst
module ddrx_init_seq
    import ddrx_pkg::*;
#(
    parameter int unsigned T_RESET_CYC = 16,
    parameter int unsigned T_CKE_CYC   = 16
) (
    input  logic              clk,
    input  logic              rst,
    config_if.slave           cfg,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output init_cmd_t         cmd_op,
    output logic [BA_W-1:0]   cmd_ba,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              dram_reset_n,
    output logic              dram_cke,
    output logic              init_done
);

    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

    init_state_t      state_q, state_d;
    logic [2:0]       step_q, step_d;
    init_cmd_s        payload_q, payload_d;
    init_cmd_s        step_cmd;
    logic [CNT_W-1:0] gap_cyc;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_expired;

    ddrx_delay_cnt #(
        .RST_VAL (CNT_W'(T_RESET_CYC))
    ) u_delay_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .value   (cnt_value),
        .expired (cnt_expired)
    );

    // Delay that follows the command of the current step, zero treated as one.
    always_comb begin
        gap_cyc = CNT_W'(1);
        case (step_q)
            3'd0, 3'd1, 3'd2: gap_cyc = min_one(CNT_W'(cfg.tMRD));
            3'd3:             gap_cyc = min_one(CNT_W'(cfg.tMOD));
            default:          gap_cyc = min_one(CNT_W'(cfg.tZQinit));
        endcase
    end

    // Next state, step and counter load.
    // The handshake cycle is the first cycle of the gap, so the counter is
    // loaded with gap-1 and a 1-cycle gap goes straight to the next command.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        cnt_load  = 1'b0;
        cnt_value = '0;
        case (state_q)
            RST_HOLD: begin
                if (cnt_expired) begin
                    state_d   = CKE_WAIT;
                    cnt_load  = 1'b1;
                    cnt_value = CNT_W'(T_CKE_CYC);
                end
            end
            CKE_WAIT: begin
                if (cnt_expired) begin
                    state_d   = XPR_WAIT;
                    cnt_load  = 1'b1;
                    cnt_value = min_one(CNT_W'(cfg.tXPR));
                end
            end
            XPR_WAIT: begin
                if (cnt_expired) begin
                    state_d = ISSUE;
                    step_d  = 3'd0;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    if (gap_cyc == CNT_W'(1)) begin
                        if (step_q == LAST_STEP) begin
                            state_d = DONE;
                        end else begin
                            step_d = step_q + 3'd1;
                        end
                    end else begin
                        state_d   = GAP;
                        cnt_load  = 1'b1;
                        cnt_value = gap_cyc - CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (cnt_expired) begin
                    if (step_q == LAST_STEP) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        step_d  = step_q + 3'd1;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RST_HOLD;
            end
        endcase
    end

    // Command decode for the step being entered; payload is captured on
    // entry to ISSUE so it cannot move while the command path stalls.
    always_comb begin
        step_cmd = '{op: MRS, ba: '0, addr: '0};
        case (step_d)
            3'd0: step_cmd = '{op: MRS, ba: 3'd2, addr: cfg.msr2};
            3'd1: step_cmd = '{op: MRS, ba: 3'd3, addr: cfg.msr3};
            3'd2: step_cmd = '{op: MRS, ba: 3'd1, addr: cfg.msr1};
            3'd3: step_cmd = '{op: MRS, ba: 3'd0, addr: cfg.msr0};
            default: step_cmd = '{op: ZQCL, ba: '0, addr: ZQCL_ADDR};
        endcase

        payload_d = '{op: NOP, ba: '0, addr: '0};
        if (state_d == ISSUE) begin
            if ((state_q != ISSUE) || cmd_ready) begin
                payload_d = step_cmd;
            end else begin
                payload_d = payload_q;
            end
        end
    end

    // State, step and payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RST_HOLD;
            step_q    <= 3'd0;
            payload_q <= '{op: NOP, ba: '0, addr: '0};
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            payload_q <= payload_d;
        end
    end

    assign cmd_valid    = (state_q == ISSUE);
    assign cmd_op       = payload_q.op;
    assign cmd_ba       = payload_q.ba;
    assign cmd_addr     = payload_q.addr;
    assign dram_reset_n = (state_q != RST_HOLD);
    assign dram_cke     = (state_q != RST_HOLD) && (state_q != CKE_WAIT);
    assign init_done    = (state_q == DONE);

endmodule

// File: tb/tb_ddrx_init_seq.sv
// Directed bench for ddrx_init_seq: per-cycle output traces compared
// against hand-computed vectors, plus stall, zero-delay, reset and
// config-change sequences.
module tb_ddrx_init_seq;
    import ddrx_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_ready = 1'b0;
    logic              cmd_valid;
    init_cmd_t         cmd_op;
    logic [2:0]        cmd_ba;
    logic [12:0]       cmd_addr;
    logic              dram_reset_n;
    logic              dram_cke;
    logic              init_done;

    config_if cfg_if ();

    ddrx_init_seq #(
        .T_RESET_CYC (16),
        .T_CKE_CYC   (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg          (cfg_if),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_ba       (cmd_ba),
        .cmd_addr     (cmd_addr),
        .dram_reset_n (dram_reset_n),
        .dram_cke     (dram_cke),
        .init_done    (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        rn;
        logic        cke;
        logic        v;
        logic [1:0]  op;
        logic [2:0]  ba;
        logic [12:0] addr;
        logic        done;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [21:0] tr [0:127];
    int          bp_start = -1;
    int          bp_len = 0;
    int          tmod_chg = -1;
    vec_t        vq [$];

    // Packed view: {rn, cke, valid, op[1:0], ba[2:0], addr[12:0], done}
    function automatic logic [21:0] cur_out();
        return {dram_reset_n, dram_cke, cmd_valid, cmd_op, cmd_ba, cmd_addr, init_done};
    endfunction

    function automatic vec_t mk(input int c, input logic rn, input logic cke, input logic v,
                                input logic [1:0] op, input logic [2:0] ba,
                                input logic [12:0] a, input logic d);
        vec_t r;
        r.cyc = c; r.rn = rn; r.cke = cke; r.v = v;
        r.op = op; r.ba = ba; r.addr = a; r.done = d;
        return r;
    endfunction

    task automatic check_vec(input string tag, input vec_t v);
        logic [21:0] exp;
        exp = {v.rn, v.cke, v.v, v.op, v.ba, v.addr, v.done};
        checks++;
        if (tr[v.cyc] !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %h want %h", tag, v.cyc, tr[v.cyc], exp);
        end
    endtask

    task automatic check_val(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic run_table(input string tag);
        foreach (vq[i]) check_vec(tag, vq[i]);
        vq.delete();
    endtask

    // Reset, release at a falling edge (cycle 0), then record ncyc cycles.
    task automatic run_seq(input int ncyc);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < ncyc; j++) begin
            if (j > 0) @(negedge clk);
            if (j == tmod_chg) cfg_if.tMOD = 5'd3;
            cmd_ready = !((j >= bp_start) && (j < bp_start + bp_len));
            tr[j] = cur_out();
        end
    endtask

    function automatic int count_valid(input int lo, input int hi);
        int n = 0;
        for (int j = lo; j <= hi; j++) if (tr[j][19]) n++;
        return n;
    endfunction

    task automatic set_nominal();
        cfg_if.msr0    = 13'h1D70;
        cfg_if.msr1    = 13'h0044;
        cfg_if.msr2    = 13'h0018;
        cfg_if.msr3    = 13'h0000;
        cfg_if.tXPR    = 5'd5;
        cfg_if.tMRD    = 4'd4;
        cfg_if.tMOD    = 5'd12;
        cfg_if.tZQinit = 5'd15;
    endtask

    initial begin
        set_nominal();

        // Nominal sequence with decode values
        run_seq(100);
        vq.push_back(mk( 0, 0, 0, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(15, 0, 0, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(16, 1, 0, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(31, 1, 0, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(32, 1, 1, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(36, 1, 1, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(37, 1, 1, 1, 1, 2, 13'h0018, 0));
        vq.push_back(mk(38, 1, 1, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(40, 1, 1, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(41, 1, 1, 1, 1, 3, 13'h0000, 0));
        vq.push_back(mk(44, 1, 1, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(45, 1, 1, 1, 1, 1, 13'h0044, 0));
        vq.push_back(mk(49, 1, 1, 1, 1, 0, 13'h1D70, 0));
        vq.push_back(mk(50, 1, 1, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(60, 1, 1, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(61, 1, 1, 1, 2, 0, 13'h0400, 0));
        vq.push_back(mk(62, 1, 1, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(75, 1, 1, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(76, 1, 1, 0, 0, 0, 13'h0000, 1));
        vq.push_back(mk(99, 1, 1, 0, 0, 0, 13'h0000, 1));
        run_table("nominal");
        check_val("nominal_valid_cycles", count_valid(0, 99), 5);

        // Backpressure: cmd_ready low for cycles 41..47 during MR3
        bp_start = 41;
        bp_len   = 7;
        run_seq(100);
        for (int c = 41; c <= 48; c++) vq.push_back(mk(c, 1, 1, 1, 1, 3, 13'h0000, 0));
        vq.push_back(mk(40, 1, 1, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(49, 1, 1, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(51, 1, 1, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(52, 1, 1, 1, 1, 1, 13'h0044, 0));
        vq.push_back(mk(56, 1, 1, 1, 1, 0, 13'h1D70, 0));
        vq.push_back(mk(67, 1, 1, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(68, 1, 1, 1, 2, 0, 13'h0400, 0));
        vq.push_back(mk(82, 1, 1, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(83, 1, 1, 0, 0, 0, 13'h0000, 1));
        run_table("backpressure");
        bp_start = -1;
        bp_len   = 0;

        // Zero delays: every wait behaves as one cycle
        cfg_if.tXPR    = 5'd0;
        cfg_if.tMRD    = 4'd0;
        cfg_if.tMOD    = 5'd0;
        cfg_if.tZQinit = 5'd0;
        run_seq(60);
        vq.push_back(mk(32, 1, 1, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(33, 1, 1, 1, 1, 2, 13'h0018, 0));
        vq.push_back(mk(34, 1, 1, 1, 1, 3, 13'h0000, 0));
        vq.push_back(mk(35, 1, 1, 1, 1, 1, 13'h0044, 0));
        vq.push_back(mk(36, 1, 1, 1, 1, 0, 13'h1D70, 0));
        vq.push_back(mk(37, 1, 1, 1, 2, 0, 13'h0400, 0));
        vq.push_back(mk(38, 1, 1, 0, 0, 0, 13'h0000, 1));
        run_table("zero_delay");
        check_val("zero_delay_valid_cycles", count_valid(0, 59), 5);
        set_nominal();

        // tMOD changed during the MR0 gap has no effect on the running wait
        tmod_chg = 52;
        run_seq(100);
        vq.push_back(mk(55, 1, 1, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(60, 1, 1, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(61, 1, 1, 1, 2, 0, 13'h0400, 0));
        vq.push_back(mk(75, 1, 1, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(76, 1, 1, 0, 0, 0, 13'h0000, 1));
        run_table("cfg_change");
        tmod_chg = -1;
        set_nominal();

        // Reset asserted while MR1 is offered, then full restart
        run_seq(46);
        vq.push_back(mk(45, 1, 1, 1, 1, 1, 13'h0044, 0));
        run_table("mid_reset_pre");
        #2 rst = 1'b1;
        #1;
        check_val("mid_reset_async_outputs", int'(cur_out()), 0);
        run_seq(40);
        vq.push_back(mk(15, 0, 0, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(16, 1, 0, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(36, 1, 1, 0, 0, 0, 13'h0000, 0));
        vq.push_back(mk(37, 1, 1, 1, 1, 2, 13'h0018, 0));
        run_table("mid_reset_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
